// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command-frame controller.
package uart_cmd_pkg;

  localparam int DBIT_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GET_A  = 3'd1,
    S_GET_B  = 3'd2,
    S_EXEC   = 3'd3,
    S_SEND_S = 3'd4,
    S_SEND_R = 3'd5
  } state_t;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_AND  = 8'h03;
  localparam logic [7:0] OP_OR   = 8'h04;
  localparam logic [7:0] OP_XOR  = 8'h05;
  localparam logic [7:0] OP_ECHO = 8'h06;

  localparam logic [7:0] ST_OK    = 8'h00;
  localparam logic [7:0] ST_CARRY = 8'h01;
  localparam logic [7:0] ST_BADOP = 8'hEE;
  localparam logic [7:0] ST_TMO   = 8'hE0;

endpackage

// File: rtl/uart_cmd_alu.sv
// Combinational ALU for one command frame: opcode, operand A, operand B.
module uart_cmd_alu
  import uart_cmd_pkg::*;
#(
  parameter int DBIT = DBIT_DEF
) (
  input  logic [DBIT-1:0] op,
  input  logic [DBIT-1:0] a,
  input  logic [DBIT-1:0] b,
  output logic [DBIT-1:0] result,
  output logic [DBIT-1:0] status
);

  logic [DBIT:0] sum;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    result = '0;
    status = DBIT'(ST_OK);
    case (op)
      DBIT'(OP_ADD): begin
        result = sum[DBIT-1:0];
        if (sum[DBIT]) status = DBIT'(ST_CARRY);
      end
      DBIT'(OP_SUB): begin
        result = a - b;
        if (a < b) status = DBIT'(ST_CARRY);
      end
      DBIT'(OP_AND):  result = a & b;
      DBIT'(OP_OR):   result = a | b;
      DBIT'(OP_XOR):  result = a ^ b;
      DBIT'(OP_ECHO): result = a;
      default:        status = DBIT'(ST_BADOP);
    endcase
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Pops 3-byte command frames from the RX FIFO, runs the ALU and pushes a
// status/result pair into the TX FIFO; partial frames are dropped on timeout.
//
// state    | meaning
// IDLE     | wait for opcode byte
// GET_A    | wait for operand A (timeout armed)
// GET_B    | wait for operand B (timeout armed)
// EXEC     | register ALU status/result
// SEND_S   | push status byte when TX has room
// SEND_R   | push result byte, bump frame count
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [DBIT-1:0] r_data,
  input  logic            rx_empty,
  output logic            rd,
  output logic [DBIT-1:0] w_data,
  output logic            wr,
  input  logic            tx_full,
  output logic            busy,
  output logic [7:0]      frame_cnt
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [DBIT-1:0] op_q, op_d, a_q, a_d, b_q, b_d;
  logic [DBIT-1:0] status_q, status_d, result_q, result_d;
  logic [DBIT-1:0] alu_result, alu_status;
  logic [DBIT-1:0] w_data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      frame_d;
  logic            rd_d, wr_d;
  logic            accept, send_ok;

  uart_cmd_alu #(.DBIT(DBIT)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .status (alu_status)
  );

  // The rd/wr guards keep a stale FIFO head or a full flag from being used twice.
  assign accept  = !rx_empty && !rd;
  assign send_ok = !tx_full && !wr;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    status_d = status_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    w_data_d = w_data;
    frame_d  = frame_cnt;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          op_d    = r_data;
          rd_d    = 1'b1;
          state_d = S_GET_A;
        end
      end
      S_GET_A, S_GET_B: begin
        if (accept) begin
          if (state_q == S_GET_A) begin
            a_d     = r_data;
            state_d = S_GET_B;
          end else begin
            b_d     = r_data;
            state_d = S_EXEC;
          end
          rd_d  = 1'b1;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          status_d = DBIT'(ST_TMO);
          result_d = '0;
          cnt_d    = '0;
          state_d  = S_SEND_S;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        status_d = alu_status;
        result_d = alu_result;
        state_d  = S_SEND_S;
      end
      S_SEND_S: begin
        if (send_ok) begin
          w_data_d = status_q;
          wr_d     = 1'b1;
          state_d  = S_SEND_R;
        end
      end
      S_SEND_R: begin
        if (send_ok) begin
          w_data_d = result_q;
          wr_d     = 1'b1;
          frame_d  = frame_cnt + 8'd1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      status_q  <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      rd        <= 1'b0;
      wr        <= 1'b0;
      w_data    <= '0;
      frame_cnt <= 8'd0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      status_q  <= status_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      rd        <= rd_d;
      wr        <= wr_d;
      w_data    <= w_data_d;
      frame_cnt <= frame_d;
      busy      <= (state_d != S_IDLE);
    end
  end

endmodule
